poly_mult_host_seq: RTL and testbench

On-FPGA command initiator that drives the CW305 `poly_mult_top` load/key/data command interface from the target side of the host link. It replaces the USB host for self-test and throughput runs. One `go` loads WEIGHT shift positions and NWORDS random-vector words, issues the compute command, waits for the multiplier to finish, and returns the 128-bit result word. Every command is a single-cycle `load_o` pulse, paced by the target's `busy` handshake and guarded by a timeout.

---
 rtl/poly_mult_host_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_poly_mult_host_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mult_host_seq.sv
// poly_mult_host_seq
// On-FPGA command initiator for the poly_mult_top load/key/data interface.
// One accepted `go` performs this sequence:
//   1. write WEIGHT shift positions (keys 0..WEIGHT-1);
//   2. write NWORDS random-vector words (keys WEIGHT..WEIGHT+NWORDS-1);
//   3. issue the all-ones compute command on START_KEY;
//   4. wait for the target to finish;
//   5. capture the 128-bit result.
// Each command is a single-cycle load_o pulse. The target acknowledges it with
// a busy high/low handshake, and every handshake is guarded by a timeout.
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   go                         : start a sequence (sampled in IDLE only)
//   pos_valid/pos_ready/pos_data     : position stream, WEIGHT beats
//   word_valid/word_ready/word_data  : random-word stream, NWORDS beats
//   load_o, key_o, cmd_data_o  : registered command strobe, key, data
//   tgt_busy_i, tgt_data_i     : target busy flag and result data
//   res_valid, res_data        : one-cycle result pulse, held result
//   done, error                : sequence ended / ended by timeout
module poly_mult_host_seq #(
    parameter int          WEIGHT    = 2,
    parameter int          NWORDS    = 553,
    parameter int          LOGW      = 16,
    parameter logic [9:0]  START_KEY = 10'h3FF,
    parameter int          TIMEOUT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic [LOGW-1:0]   pos_data,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [31:0]       word_data,
    output logic              load_o,
    output logic [9:0]        key_o,
    output logic [127:0]      cmd_data_o,
    input  logic              tgt_busy_i,
    input  logic [127:0]      tgt_data_i,
    output logic              res_valid,
    output logic [127:0]      res_data,
    output logic              done,
    output logic              error
);

    localparam int MAX_BEATS = (WEIGHT > NWORDS) ? WEIGHT : NWORDS;
    localparam int IDX_W     = $clog2(MAX_BEATS + 1);

    // Timeout fires on the (2^TIMEOUT_W - 1)th cycle spent waiting.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0]     POS_END  = IDX_W'(WEIGHT);
    localparam logic [IDX_W-1:0]     WORD_END = IDX_W'(NWORDS);
    localparam logic [9:0]           WORD_KEY0 = 10'(WEIGHT);

    typedef enum logic [2:0] {
        IDLE, POS, WORD, START, ACK_HI, ACK_LO, CAPTURE, FIN
    } state_t;

    state_t                 state;
    state_t                 ret_state;
    logic [IDX_W-1:0]       idx;
    logic [TIMEOUT_W-1:0]   tmo;

    // A data value of 0 is decoded by the target as a read, so a guard bit
    // just above the payload keeps every write command non-zero.
    function automatic logic [127:0] pos_cmd(input logic [LOGW-1:0] p);
        logic [127:0] c;
        c           = '0;
        c[LOGW-1:0] = p;
        c[LOGW]     = 1'b1;
        return c;
    endfunction

    function automatic logic [127:0] word_cmd(input logic [31:0] w);
        logic [127:0] c;
        c         = '0;
        c[31:0]   = w;
        c[32]     = 1'b1;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            idx        <= '0;
            tmo        <= '0;
            load_o     <= 1'b0;
            key_o      <= '0;
            cmd_data_o <= '0;
            pos_ready  <= 1'b0;
            word_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            load_o    <= 1'b0;
            res_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (go) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        idx   <= '0;
                        if (WEIGHT == 0) begin
                            state      <= WORD;
                            word_ready <= 1'b1;
                        end else begin
                            state     <= POS;
                            pos_ready <= 1'b1;
                        end
                    end
                end

                POS: begin
                    if (pos_valid && pos_ready) begin
                        load_o     <= 1'b1;
                        key_o      <= 10'(idx);
                        cmd_data_o <= pos_cmd(pos_data);
                        pos_ready  <= 1'b0;
                        idx        <= idx + 1'b1;
                        tmo        <= '0;
                        ret_state  <= POS;
                        state      <= ACK_HI;
                    end
                end

                WORD: begin
                    if (word_valid && word_ready) begin
                        load_o     <= 1'b1;
                        key_o      <= WORD_KEY0 + 10'(idx);
                        cmd_data_o <= word_cmd(word_data);
                        word_ready <= 1'b0;
                        idx        <= idx + 1'b1;
                        tmo        <= '0;
                        ret_state  <= WORD;
                        state      <= ACK_HI;
                    end
                end

                START: begin
                    load_o     <= 1'b1;
                    key_o      <= START_KEY;
                    cmd_data_o <= '1;
                    tmo        <= '0;
                    ret_state  <= CAPTURE;
                    state      <= ACK_HI;
                end

                // A busy level already high here counts on the first cycle,
                // so even a single-cycle busy glitch acknowledges the command.
                ACK_HI: begin
                    if (tgt_busy_i) begin
                        state <= ACK_LO;
                    end else if (tmo == TMO_LAST) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                // Busy has dropped: resume the stream, move to the next
                // phase, or fetch the result after the compute command.
                ACK_LO: begin
                    if (!tgt_busy_i) begin
                        case (ret_state)
                            POS: begin
                                if (idx == POS_END) begin
                                    idx <= '0;
                                    if (NWORDS == 0) begin
                                        state <= START;
                                    end else begin
                                        state      <= WORD;
                                        word_ready <= 1'b1;
                                    end
                                end else begin
                                    state     <= POS;
                                    pos_ready <= 1'b1;
                                end
                            end
                            WORD: begin
                                if (idx == WORD_END) begin
                                    state <= START;
                                end else begin
                                    state      <= WORD;
                                    word_ready <= 1'b1;
                                end
                            end
                            default: state <= CAPTURE;
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                CAPTURE: begin
                    res_data  <= tgt_data_i;
                    res_valid <= 1'b1;
                    state     <= FIN;
                end

                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mult_host_seq.sv
// Testbench for poly_mult_host_seq.
// The bench includes a behavioural target that pulses busy for one cycle
// after each write. After a compute command it holds busy for five cycles,
// unless it is in hang mode. Its result is the 128-bit sum of the write
// data. Expected command and result queues are filled when a sequence is
// issued; a monitor pops them whenever load_o or res_valid is seen.
module tb_poly_mult_host_seq;

    localparam int NW = 553;

    typedef struct packed {
        logic [9:0]   key;
        logic [127:0] data;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic         pos_valid;
    logic         pos_ready;
    logic [15:0]  pos_data;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_data;
    logic         load_o;
    logic [9:0]   key_o;
    logic [127:0] cmd_data_o;
    logic         tgt_busy_i;
    logic [127:0] tgt_data_i;
    logic         res_valid;
    logic [127:0] res_data;
    logic         done;
    logic         error;

    int checks = 0;
    int errors = 0;
    int res_seen = 0;

    cmd_t         exp_cmd[$];
    logic [127:0] exp_res[$];
    logic [15:0]  pos_q[$];
    logic [31:0]  word_q[$];

    bit   stall = 1'b0;
    bit   hang  = 1'b0;
    bit   tog   = 1'b0;
    logic prev_load = 1'b0;
    int   bcnt;

    poly_mult_host_seq #(
        .WEIGHT(2), .NWORDS(NW), .LOGW(16), .START_KEY(10'h3FF), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .load_o(load_o), .key_o(key_o), .cmd_data_o(cmd_data_o),
        .tgt_busy_i(tgt_busy_i), .tgt_data_i(tgt_data_i),
        .res_valid(res_valid), .res_data(res_data),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Target model
    assign tgt_busy_i = (bcnt != 0);
    logic [127:0] acc;
    always @(posedge clk) begin
        if (rst) begin
            bcnt       <= 0;
            acc        <= '0;
            tgt_data_i <= '0;
        end else if (load_o) begin
            if (key_o == 10'h3FF) begin
                acc <= '0;
                if (!hang) begin
                    bcnt       <= 5;
                    tgt_data_i <= acc;
                end
            end else begin
                acc  <= acc + cmd_data_o;
                bcnt <= 1;
            end
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    // Stream drivers
    always @(negedge clk) begin
        tog        = ~tog;
        pos_valid  = (pos_q.size() != 0) && (!stall || tog);
        pos_data   = (pos_q.size() != 0) ? pos_q[0] : 16'h0;
        word_valid = (word_q.size() != 0) && (!stall || tog);
        word_data  = (word_q.size() != 0) ? word_q[0] : 32'h0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (pos_valid && pos_ready)   void'(pos_q.pop_front());
            if (word_valid && word_ready) void'(word_q.pop_front());
        end
    end

    // Monitor
    always @(negedge clk) begin
        cmd_t e;
        if (!rst) begin
            if (load_o) begin
                chk("load_width", {127'b0, prev_load}, 128'd0);
                if (key_o < 10'd2) chk("pos_guard_bit", {127'b0, cmd_data_o[16]}, 128'd1);
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual_key=%h required=none", key_o);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_key", {118'b0, key_o}, {118'b0, e.key});
                    chk("cmd_data", cmd_data_o, e.data);
                end
            end
            if (res_valid) begin
                res_seen++;
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none", res_data);
                end else begin
                    chk("result", res_data, exp_res.pop_front());
                end
            end
        end
        prev_load = load_o;
    end

    task automatic fill(input int pat, input bit hang_m);
        logic [127:0] sum;
        logic [127:0] d;
        logic [15:0]  p;
        logic [31:0]  w;
        sum = '0;
        for (int i = 0; i < 2; i++) begin
            if (pat == 0) p = (i == 0) ? 16'h0000 : 16'h1234;
            else          p = (i == 0) ? 16'hFFFF : 16'h0001;
            d = {111'b0, 1'b1, p};
            pos_q.push_back(p);
            exp_cmd.push_back({10'(i), d});
            sum = sum + d;
        end
        for (int i = 0; i < NW; i++) begin
            w = (pat == 0) ? 32'(i) : ~32'(i);
            d = {95'b0, 1'b1, w};
            word_q.push_back(w);
            exp_cmd.push_back({10'(2 + i), d});
            sum = sum + d;
        end
        exp_cmd.push_back({10'h3FF, {128{1'b1}}});
        if (!hang_m) exp_res.push_back(sum);
    endtask

    task automatic run_seq(input int pat, input bit stall_m, input bit hang_m, input bit glitch);
        int cyc;
        int t_start;
        bit glitched;
        fill(pat, hang_m);
        stall    = stall_m;
        hang     = hang_m;
        res_seen = 0;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        cyc      = 0;
        t_start  = 0;
        glitched = 1'b0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            go = 1'b0;
            if (load_o && key_o == 10'h3FF) t_start = cyc;
            if (glitch && t_start != 0 && !glitched) begin
                go       = 1'b1;
                glitched = 1'b1;
            end
        end
        go = 1'b0;
        chk("seq_done", {127'b0, done}, 128'd1);
        chk("seq_error", {127'b0, error}, {127'b0, hang_m});
        if (hang_m) chk("timeout_cycles", 128'(cyc - t_start), 128'd15);
        repeat (4) @(negedge clk);
        chk("cmd_queue_empty", 128'(exp_cmd.size()), 128'd0);
        chk("res_queue_empty", 128'(exp_res.size()), 128'd0);
        chk("res_count", 128'(res_seen), hang_m ? 128'd0 : 128'd1);
        chk("streams_drained", 128'(pos_q.size() + word_q.size()), 128'd0);
        chk("done_held", {127'b0, done}, 128'd1);
    endtask

    task automatic run_rst();
        int cyc;
        fill(0, 1'b0);
        stall = 1'b0;
        hang  = 1'b0;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        cyc = 0;
        while (!(load_o && key_o == 10'd102) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_index_100", {118'b0, key_o}, 128'd102);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_load_low", {127'b0, load_o}, 128'd0);
        chk("rst_word_ready", {127'b0, word_ready}, 128'd0);
        chk("rst_pos_ready", {127'b0, pos_ready}, 128'd0);
        chk("rst_res_valid", {127'b0, res_valid}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        pos_q.delete();
        word_q.delete();
        exp_cmd.delete();
        exp_res.delete();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {126'b0, pos_ready, word_ready}, 128'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load_o", {127'b0, load_o}, 128'd0);
        chk("rst_key_o", {118'b0, key_o}, 128'd0);
        chk("rst_cmd_data", cmd_data_o, 128'd0);
        chk("rst_res_data", res_data, 128'd0);
        chk("rst_flags", {122'b0, pos_ready, word_ready, res_valid, done, error, load_o}, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_seq(0, 1'b0, 1'b0, 1'b0);
        run_seq(1, 1'b1, 1'b0, 1'b1);
        run_seq(0, 1'b0, 1'b1, 1'b0);
        run_rst();
        run_seq(0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
